// File: rtl/sha512_pkg.sv
// Shared SHA-512 definitions: padder states, chunk geometry, byte-lane helper.
// SHA512_PADDER_LEN128_EN widens the message byte counter to a full 128-bit length.
package sha512_pkg;

    typedef enum logic [1:0] {FILL, PAD, EMIT, TAIL} pad_state_t;
    typedef enum logic [1:0] {TAIL_NONE, TAIL_M80, TAIL_ZERO} tail_t;

    localparam int         CHUNK_BYTES = 128;
    localparam int         LEN_OFFSET  = 112;
    localparam logic [7:0] PAD_MARKER  = 8'h80;

`ifdef SHA512_PADDER_LEN128_EN
    localparam int CNT_W = 125;
`else
    localparam int CNT_W = 61;
`endif

    // Byte 0 sits in the MSBs so the chunk maps directly onto big-endian w[0].
    function automatic logic [1023:0] put_byte(input logic [1023:0] b,
                                               input logic [7:0]    idx,
                                               input logic [7:0]    val);
        logic [1023:0] r;
        r = b;
        r[(CHUNK_BYTES - 1 - int'(idx)) * 8 +: 8] = val;
        return r;
    endfunction

endpackage

// File: rtl/sha512_padder.sv
// Byte stream to padded 1024-bit SHA-512 chunks; 1 byte/cycle in, chunk held until chunk_ready.
// Options: SHA512_PADDER_LEN128_EN selects a 128-bit length field (default 64-bit).
module sha512_padder
    import sha512_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_byte,
    input  logic          in_last,
    output logic          chunk_valid,
    input  logic          chunk_ready,
    output logic [1023:0] chunk,
    output logic          chunk_last
);

    localparam int LEN_W = (CHUNK_BYTES - LEN_OFFSET) * 8;

    pad_state_t       state;
    tail_t            tail;
    logic [7:0]       ptr;
    logic [7:0]       ptr_nxt;
    logic [CNT_W-1:0] cnt;
    logic [LEN_W-1:0] len_bits;
    logic             len_fits;
    logic [1023:0]    pad_buf;
    logic [1023:0]    tail_buf;

`ifdef SHA512_PADDER_LEN128_EN
    assign len_bits = {cnt, 3'b000};
`else
    assign len_bits = {64'd0, cnt, 3'b000};
`endif

    assign ptr_nxt  = ptr + 8'd1;
    assign len_fits = (ptr <= 8'(LEN_OFFSET - 1));
    assign in_ready = reset && (state == FILL);

    // The chunk register doubles as the fill buffer; PAD and TAIL rewrite it in place.
    always_comb begin
        pad_buf = put_byte(chunk, ptr, PAD_MARKER);
        for (int i = 0; i < CHUNK_BYTES; i++) begin
            if (i > int'(ptr)) begin
                pad_buf[(CHUNK_BYTES - 1 - i) * 8 +: 8] = 8'h00;
            end
        end
        if (len_fits) begin
            pad_buf[LEN_W-1:0] = len_bits;
        end

        tail_buf = '0;
        if (tail == TAIL_M80) begin
            tail_buf[1023 -: 8] = PAD_MARKER;
        end
        tail_buf[LEN_W-1:0] = len_bits;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= FILL;
            tail        <= TAIL_NONE;
            ptr         <= 8'd0;
            cnt         <= '0;
            chunk       <= '0;
            chunk_valid <= 1'b0;
            chunk_last  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        chunk <= put_byte(chunk, ptr, in_byte);
                        ptr   <= ptr_nxt;
                        cnt   <= cnt + CNT_W'(1);
                        if (ptr_nxt == 8'(CHUNK_BYTES)) begin
                            // A message ending exactly on a chunk boundary still owes a marker chunk.
                            state       <= EMIT;
                            chunk_valid <= 1'b1;
                            chunk_last  <= 1'b0;
                            if (in_last) begin
                                tail <= TAIL_M80;
                            end
                        end else if (in_last) begin
                            state <= PAD;
                        end
                    end
                end
                PAD: begin
                    chunk       <= pad_buf;
                    chunk_valid <= 1'b1;
                    state       <= EMIT;
                    if (len_fits) begin
                        chunk_last <= 1'b1;
                    end else begin
                        chunk_last <= 1'b0;
                        tail       <= TAIL_ZERO;
                    end
                end
                EMIT: begin
                    if (chunk_ready) begin
                        chunk_valid <= 1'b0;
                        ptr         <= 8'd0;
                        if (tail != TAIL_NONE) begin
                            state <= TAIL;
                        end else begin
                            state <= FILL;
                            if (chunk_last) begin
                                cnt <= '0;
                            end
                        end
                    end
                end
                TAIL: begin
                    chunk       <= tail_buf;
                    chunk_last  <= 1'b1;
                    chunk_valid <= 1'b1;
                    tail        <= TAIL_NONE;
                    state       <= EMIT;
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha512_padder.sv
// Bench for sha512_padder: vector table, timing/stall/reset sequences, random messages vs padding model.
module tb_sha512_padder;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [7:0]    in_byte = 8'h00;
    logic          chunk_ready = 1'b0;
    logic          in_ready;
    logic          chunk_valid;
    logic          chunk_last;
    logic [1023:0] chunk;

    int checks = 0;
    int errors = 0;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [1023:0] dat;
        logic          last;
    } exp_t;

    typedef struct {
        int           len;
        int           pat;
        int           exp_chunks;
        logic [127:0] exp_len;
    } vec_t;

    exp_t          exp_q[$];
    int            rx_count = 0;
    logic [1023:0] last_rx = '0;
    int            rdy_mode = 0;

    sha512_padder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_byte     (in_byte),
        .in_last     (in_last),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk       (chunk),
        .chunk_last  (chunk_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_chunk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        int k;
        checks++;
        if (act !== exp) begin
            k = 0;
            while (k < 127 && act[1023 - 8 * k -: 8] === exp[1023 - 8 * k -: 8]) k++;
            errors++;
            $display("FAIL %s: byte %0d got %02h, expected %02h", name, k,
                     act[1023 - 8 * k -: 8], exp[1023 - 8 * k -: 8]);
        end
    endtask

    // FIPS 180-4 padding on a whole byte array, then sliced into chunks.
    function automatic void model(input bq_t msg);
        bq_t          p;
        logic [127:0] len;
        exp_t         e;
        int           nch;
        p   = msg;
        len = 128'(msg.size()) << 3;
        p.push_back(8'h80);
        while (p.size() % 128 != 112) p.push_back(8'h00);
        for (int i = 15; i >= 0; i--) p.push_back(len[8 * i +: 8]);
        nch = p.size() / 128;
        for (int c = 0; c < nch; c++) begin
            for (int k = 0; k < 128; k++) e.dat[1023 - 8 * k -: 8] = p[c * 128 + k];
            e.last = (c == nch - 1);
            exp_q.push_back(e);
        end
    endfunction

    function automatic bq_t make_msg(input int len, input int pat);
        bq_t m;
        for (int k = 0; k < len; k++) begin
            case (pat)
                0:       m.push_back(8'h00);
                1:       m.push_back(8'hFF);
                2:       m.push_back(8'(k));
                default: m.push_back(8'($urandom));
            endcase
        end
        return m;
    endfunction

    function automatic bq_t abc_msg();
        bq_t m;
        m.push_back(8'h61);
        m.push_back(8'h62);
        m.push_back(8'h63);
        return m;
    endfunction

    function automatic exp_t abc_exp();
        exp_t e;
        e.dat            = '0;
        e.dat[1023 -: 32] = 32'h61626380;
        e.dat[127:0]     = 128'h18;
        e.last           = 1'b1;
        return e;
    endfunction

    // Handshakes are judged at the falling edge; inputs only move 1 time unit after the rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset && chunk_valid && chunk_ready) begin
            rx_count++;
            last_rx = chunk;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_chunk: got chunk_last=%0b, expected no chunk", chunk_last);
            end else begin
                e = exp_q.pop_front();
                chk_chunk("chunk_data", chunk, e.dat);
                chk("chunk_last", 128'(chunk_last), 128'(e.last));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0) chunk_ready = 1'b1;
        else if (rdy_mode == 1) chunk_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input bq_t msg, input int max_gap, input bit with_last);
        int w;
        for (int i = 0; i < msg.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_byte  = msg[i];
            in_last  = with_last && (i == msg.size() - 1);
            w = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                w++;
                if (w > 2000) break;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (w > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected 1", w);
                return;
            end
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d chunks pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_chunk_valid", 128'(chunk_valid), 128'd0);
        chk("rst_chunk_last", 128'(chunk_last), 128'd0);
        chk_chunk("rst_chunk", chunk, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("in_ready_after_reset", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic one_handshake();
        @(posedge clk);
        #1;
        chunk_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chunk_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[10];
        bq_t           msg;
        exp_t          e;
        int            start;
        logic [1023:0] held;
        logic          ok;

        vecs[0] = '{1,   2, 1, 128'h8};
        vecs[1] = '{111, 0, 1, 128'h378};
        vecs[2] = '{112, 0, 2, 128'h380};
        vecs[3] = '{128, 1, 2, 128'h400};
        vecs[4] = '{127, 2, 2, 128'h3f8};
        vecs[5] = '{113, 3, 2, 128'h388};
        vecs[6] = '{200, 2, 2, 128'h640};
        vecs[7] = '{239, 3, 2, 128'h778};
        vecs[8] = '{240, 3, 3, 128'h780};
        vecs[9] = '{256, 1, 3, 128'h800};

        do_reset();

        for (int v = 0; v < 10; v++) begin
            rdy_mode = v % 2;
            msg = make_msg(vecs[v].len, vecs[v].pat);
            model(msg);
            start = rx_count;
            send(msg, v % 3, 1'b1);
            drain();
            chk($sformatf("num_chunks_len%0d", vecs[v].len), 128'(rx_count - start),
                128'(vecs[v].exp_chunks));
            chk($sformatf("len_field_len%0d", vecs[v].len), last_rx[127:0], vecs[v].exp_len);
        end

        // "abc": valid two cycles after the last byte, then a 10-cycle stall.
        rdy_mode    = 2;
        chunk_ready = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(abc_exp());
        send(abc_msg(), 0, 1'b1);
        @(negedge clk);
        chk("abc_valid_t1", 128'(chunk_valid), 128'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abc_valid_t2", 128'(chunk_valid), 128'd1);
        held = chunk;
        for (int s = 0; s < 10; s++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            ok = (chunk === held) && (chunk_last === 1'b1) && (chunk_valid === 1'b1) && (in_ready === 1'b0);
            chk("stall_stable", 128'(ok), 128'd1);
        end
        one_handshake();
        @(negedge clk);
        chk("single_handshake", 128'(chunk_valid), 128'd0);
        chk("in_ready_after_final", 128'(in_ready), 128'd1);
        chk("abc_drained", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;

        // 128 bytes of 0xFF: full chunk next cycle, M80 tail two cycles after handshake.
        msg = make_msg(128, 1);
        model(msg);
        send(msg, 0, 1'b1);
        @(negedge clk);
        chk("full_valid_t1", 128'(chunk_valid), 128'd1);
        chk("full_last", 128'(chunk_last), 128'd0);
        one_handshake();
        @(negedge clk);
        chk("tail_valid_t1", 128'(chunk_valid), 128'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("tail_valid_t2", 128'(chunk_valid), 128'd1);
        one_handshake();
        drain();

        // Reset after 50 bytes of a message, then "abc" must come out unchanged.
        rdy_mode = 0;
        send(make_msg(50, 3), 0, 1'b0);
        do_reset();
        start = rx_count;
        exp_q.push_back(abc_exp());
        send(abc_msg(), 0, 1'b1);
        drain();
        chk("abc_after_reset_count", 128'(rx_count - start), 128'd1);

        // Reset while a chunk is waiting in EMIT.
        rdy_mode    = 2;
        chunk_ready = 1'b0;
        @(posedge clk);
        #1;
        send(abc_msg(), 0, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("emit_before_reset", 128'(chunk_valid), 128'd1);
        do_reset();
        rdy_mode = 0;
        exp_q.push_back(abc_exp());
        send(abc_msg(), 1, 1'b1);
        drain();

        // Random messages back to back under random backpressure.
        rdy_mode = 1;
        for (int r = 0; r < 20; r++) begin
            msg = make_msg($urandom_range(1, 300), 3);
            model(msg);
            send(msg, 3, 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
